jellyvl_etherneco_synctimer_slave_cmd: RTL and testbench
========================================================

Name: jellyvl_etherneco_synctimer_slave_cmd

Overview:
- Node-side consumer of the synctimer command frame emitted by the ring master (cmd byte, 8-byte master time, 4-byte offset per node).
- Parses the frame as it passes the node.
- Uses this node's offset entry to either overwrite the local timer (override) or to nudge it via single-step adjust pulses (correct).
- Sits between the ring packet parser and the node's local synctimer timer.

Parameters:
- TIMER_WIDTH, 64, local timer width (bits).
- MAX_NODES, 2, number of offset entries in the frame.
- OFFSET_WIDTH, 24, significant offset bits (entry is 32 bits on the wire; upper bits ignored).
- RX_COMP, 0, constant (time units) subtracted from the local time captured at frame start.
- ADJUST_LIMIT, 16, maximum adjust pulses issued per frame.
- ERROR_WIDTH, 24, signed error register width.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- node_id  input  8  this node's index into the offset table.
- current_time  input  TIMER_WIDTH  local timer value.
- cmd_rx_start  input  1  frame start pulse.
- cmd_rx_end  input  1  frame end pulse.
- cmd_rx_error  input  1  frame error, qualifies cmd_rx_end.
- cmd_payload_pos  input  16  byte index within the payload.
- cmd_payload_data  input  8  payload byte.
- cmd_payload_valid  input  1  byte strobe.
- set_time  output  TIMER_WIDTH  time to load into the timer.
- set_valid  output  1  one-cycle load pulse.
- adjust_sign  output  1  1 = slow the local timer, 0 = speed it up.
- adjust_valid  output  1  adjust request.
- adjust_ready  input  1  adjust accepted.
- last_error  output  ERROR_WIDTH  signed error of the most recent correct frame.
- frame_count  output  16  good frames received, wraps.

Behaviour:
- Reset (async assert, sync release): state=IDLE; set_valid=0; adjust_valid=0; adjust_sign=0; set_time=0; last_error=0; frame_count=0; pending=0.
- States: IDLE, RECV, CALC, SET, ADJUST.
- IDLE/any state + cmd_rx_start:
  - capture start_local = current_time - RX_COMP;
  - clear the byte buffer;
  - go to RECV.
  - A start during ADJUST aborts the remaining pulses; adjust_valid drops the next cycle unless a handshake occurs in the same cycle.
- RECV: on cmd_payload_valid, store the byte by pos:
  - pos 0 → cmd flags (bit1 override, bit0 correct);
  - pos 1..8 → master_time, little-endian;
  - pos 9+4*node_id .. +3 → offset, little-endian.
  - Other positions are ignored.
  - Bytes with pos ≥ 9+4*MAX_NODES are ignored.
  - If node_id ≥ MAX_NODES, offset is 0.
- RECV + cmd_rx_end:
  - cmd_rx_error=1 → IDLE; nothing emitted; frame_count unchanged.
  - Otherwise frame_count+1 → CALC.
  - A byte valid in the same cycle as cmd_rx_end is stored.
- CALC (1 cycle):
  - expected = master_time + zero-extended offset (TIMER_WIDTH, modulo).
  - err = expected - start_local, truncated to ERROR_WIDTH, signed.
  - override=1 → SET (override has priority over correct).
  - else correct=1 → last_error=err; pending = min(|err|, ADJUST_LIMIT); adjust_sign = (err<0); go to ADJUST if pending≠0, else IDLE.
  - neither flag → IDLE.
- SET:
  - set_time = expected + (current_time - start_local), all modulo 2^TIMER_WIDTH;
  - set_valid=1 for exactly one cycle;
  - → IDLE.
  - last_error is unchanged.
- ADJUST:
  - adjust_valid=1 while pending≠0; adjust_sign is stable while valid.
  - Each cycle with valid&&ready, pending-1; when pending reaches 0, adjust_valid drops the next cycle → IDLE.
  - valid never drops without ready except on a cmd_rx_start abort.
- Latency: cmd_rx_end → set_valid = 2 cycles; cmd_rx_end → first adjust_valid = 2 cycles.
- A cmd_rx_end without a preceding cmd_rx_start (state IDLE) is ignored.
- |err| saturation: err = -2^(ERROR_WIDTH-1) → pending = ADJUST_LIMIT.

Test Plan:
- Override: node_id=1, frame flags=0x02, master_time=0x1000, offset[1]=0x20, start_local=0x500, end 10 cycles after start with current_time=0x50A → set_valid one pulse 2 cycles after end, set_time=0x102A; no adjust.
- Correct, behind: flags=0x01, master_time=100, offset=5, start_local=100 → err=+5, last_error=5, 5 pulses with adjust_sign=0, ready held 1 → adjust_valid high exactly 5 cycles.
- Correct, ahead with saturation and backpressure: err=-40, ADJUST_LIMIT=16, ready toggling 1/0 → 16 accepted pulses, adjust_sign=1, valid stable while ready=0.
- Error frame: cmd_rx_error=1 with cmd_rx_end → no set_valid/adjust_valid, frame_count unchanged; the following good frame increments frame_count by 1.
- Out-of-range node: node_id=5, MAX_NODES=2, override frame master_time=0x200 → offset=0, set_time = 0x200 + elapsed.
- Abort and reset: new cmd_rx_start while 10 pulses are pending with ready=0 → adjust_valid low next cycle; assert reset mid-RECV → all outputs are at reset values immediately (async), and a later frame is parsed normally.

Source files
------------

// File: rtl/jellyvl_etherneco_synctimer_slave_cmd.sv
// Node-side synctimer command consumer: parses the master's time/offset frame and
// either loads the local timer outright or trims it with bounded single-step adjusts.
module jellyvl_etherneco_synctimer_slave_cmd #(
  parameter int TIMER_WIDTH  = 64,
  parameter int MAX_NODES    = 2,
  parameter int OFFSET_WIDTH = 24,
  parameter int RX_COMP      = 0,
  parameter int ADJUST_LIMIT = 16,
  parameter int ERROR_WIDTH  = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             node_id,
  input  logic [TIMER_WIDTH-1:0] current_time,
  input  logic                   cmd_rx_start,
  input  logic                   cmd_rx_end,
  input  logic                   cmd_rx_error,
  input  logic [15:0]            cmd_payload_pos,
  input  logic [7:0]             cmd_payload_data,
  input  logic                   cmd_payload_valid,
  output logic [TIMER_WIDTH-1:0] set_time,
  output logic                   set_valid,
  output logic                   adjust_sign,
  output logic                   adjust_valid,
  input  logic                   adjust_ready,
  output logic [ERROR_WIDTH-1:0] last_error,
  output logic [15:0]            frame_count
);

  localparam int PEND_W = $clog2(ADJUST_LIMIT + 1);
  localparam logic [31:0] NODES = 32'(MAX_NODES);
  localparam logic [31:0] OFFSET_MASK =
    (OFFSET_WIDTH >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << OFFSET_WIDTH) - 64'd1);

  typedef enum logic [2:0] {IDLE, RECV, CALC, SET, ADJUST} state_t;

  state_t state, next_state;

  logic [TIMER_WIDTH-1:0]        start_local;
  logic [1:0]                    flags;
  logic [63:0]                   master_raw;
  logic [31:0]                   offset_raw;
  logic [PEND_W-1:0]             pending;
  logic [TIMER_WIDTH-1:0]        expected;
  logic signed [ERROR_WIDTH-1:0] err;
  logic [PEND_W-1:0]             err_mag;
  logic [16:0]                   off_base;
  logic [16:0]                   off_rel;
  logic [2:0]                    mt_idx;
  logic                          node_ok;
  logic                          offset_hit;
  logic                          master_hit;

  // |e| clipped to the per-frame pulse budget; the extra bit keeps -2^(W-1) exact.
  function automatic logic [PEND_W-1:0] sat_mag(input logic signed [ERROR_WIDTH-1:0] e);
    logic [ERROR_WIDTH:0] mag;
    mag = e[ERROR_WIDTH-1] ? ({1'b0, ~e} + (ERROR_WIDTH+1)'(1)) : {1'b0, e};
    if (mag > (ERROR_WIDTH+1)'(ADJUST_LIMIT)) return PEND_W'(ADJUST_LIMIT);
    return PEND_W'(mag);
  endfunction

  assign off_base   = 17'd9 + {7'd0, node_id, 2'b00};
  assign off_rel    = {1'b0, cmd_payload_pos} - off_base;
  assign node_ok    = {24'd0, node_id} < NODES;
  assign offset_hit = node_ok && ({1'b0, cmd_payload_pos} >= off_base) && (off_rel < 17'd4);
  assign master_hit = (cmd_payload_pos >= 16'd1) && (cmd_payload_pos <= 16'd8);
  assign mt_idx     = cmd_payload_pos[2:0] - 3'd1;

  assign expected = master_raw[TIMER_WIDTH-1:0] + TIMER_WIDTH'(offset_raw & OFFSET_MASK);
  assign err      = ERROR_WIDTH'(expected - start_local);
  assign err_mag  = sat_mag(err);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (cmd_rx_start) begin
      next_state = RECV;
    end else begin
      case (state)
        RECV:    if (cmd_rx_end) next_state = cmd_rx_error ? IDLE : CALC;
        CALC: begin
          if (flags[1])                         next_state = SET;
          else if (flags[0] && err_mag != '0)   next_state = ADJUST;
          else                                  next_state = IDLE;
        end
        SET:     next_state = IDLE;
        ADJUST:  if (adjust_ready && pending == PEND_W'(1)) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    set_valid    = (state == SET);
    adjust_valid = (state == ADJUST) && (pending != '0);
  end

  // Frame buffer: cleared at every frame start, so it needs no reset.
  always_ff @(posedge clk) begin
    if (cmd_rx_start) begin
      start_local <= current_time - TIMER_WIDTH'(RX_COMP);
      flags       <= '0;
      master_raw  <= '0;
      offset_raw  <= '0;
    end else if (state == RECV && cmd_payload_valid) begin
      if (cmd_payload_pos == 16'd0) flags <= cmd_payload_data[1:0];
      if (master_hit) master_raw[{mt_idx, 3'b000} +: 8] <= cmd_payload_data;
      if (offset_hit) offset_raw[{off_rel[1:0], 3'b000} +: 8] <= cmd_payload_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      set_time    <= '0;
      last_error  <= '0;
      adjust_sign <= 1'b0;
      pending     <= '0;
      frame_count <= '0;
    end else if (cmd_rx_start) begin
      pending <= '0;
    end else begin
      case (state)
        RECV: if (cmd_rx_end && !cmd_rx_error) frame_count <= frame_count + 16'd1;
        CALC: begin
          // Override re-adds the time spent since frame start so the load lands current.
          if (flags[1]) begin
            set_time <= expected + (current_time - start_local);
          end else if (flags[0]) begin
            last_error  <= err;
            pending     <= err_mag;
            adjust_sign <= err[ERROR_WIDTH-1];
          end
        end
        ADJUST: if (adjust_valid && adjust_ready) pending <= pending - PEND_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jellyvl_etherneco_synctimer_slave_cmd.sv
// Directed bench for the synctimer slave command block: a frame vector table plus
// hand-written backpressure, abort and asynchronous-reset sequences.
module tb_jellyvl_etherneco_synctimer_slave_cmd;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  node_id;
  logic [63:0] current_time;
  logic        cmd_rx_start, cmd_rx_end, cmd_rx_error;
  logic [15:0] cmd_payload_pos;
  logic [7:0]  cmd_payload_data;
  logic        cmd_payload_valid;
  logic [63:0] set_time;
  logic        set_valid, adjust_sign, adjust_valid, adjust_ready;
  logic [23:0] last_error;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  jellyvl_etherneco_synctimer_slave_cmd dut (
    .clk(clk), .reset(reset), .node_id(node_id), .current_time(current_time),
    .cmd_rx_start(cmd_rx_start), .cmd_rx_end(cmd_rx_end), .cmd_rx_error(cmd_rx_error),
    .cmd_payload_pos(cmd_payload_pos), .cmd_payload_data(cmd_payload_data),
    .cmd_payload_valid(cmd_payload_valid), .set_time(set_time), .set_valid(set_valid),
    .adjust_sign(adjust_sign), .adjust_valid(adjust_valid), .adjust_ready(adjust_ready),
    .last_error(last_error), .frame_count(frame_count)
  );

  typedef struct {
    logic [7:0]  node;
    logic [7:0]  flags;
    logic [63:0] master;
    logic [31:0] offset;
    logic [63:0] t_start;
    logic [63:0] t_end;
    logic        rx_err;
    logic        exp_set;
    logic [63:0] exp_time;
    int          exp_pulses;
    logic        exp_sign;
    logic [23:0] exp_lerr;
    int          exp_inc;
  } vec_t;

  vec_t        vecs[12];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] exp_fc = 16'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_at(input int pos, input vec_t v);
    if (pos == 0) return v.flags;
    if (pos >= 1 && pos <= 8) return v.master[8*(pos-1) +: 8];
    if (pos >= 9 && pos <= 16) begin
      if ((pos - 9) / 4 == int'(v.node)) return v.offset[8*((pos-9)%4) +: 8];
      return 8'hAA;
    end
    return 8'h5C;
  endfunction

  // Flags byte goes last, together with cmd_rx_end, so same-cycle storage matters.
  task automatic send_frame(input vec_t v);
    node_id      = v.node;
    current_time = v.t_start;
    cmd_rx_start = 1'b1;
    step();
    cmd_rx_start = 1'b0;
    for (int i = 0; i < 21; i++) begin
      int p;
      p = (i < 17) ? i + 1 : 29 + (i - 17);
      cmd_payload_pos   = 16'(p);
      cmd_payload_data  = byte_at(p, v);
      cmd_payload_valid = 1'b1;
      step();
    end
    cmd_payload_pos  = 16'd0;
    cmd_payload_data = v.flags;
    current_time     = v.t_end;
    cmd_rx_end       = 1'b1;
    cmd_rx_error     = v.rx_err;
    step();
    cmd_rx_end        = 1'b0;
    cmd_rx_error      = 1'b0;
    cmd_payload_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int          first, nset, npul;
    logic [63:0] st;
    logic        sg;
    first = 0; nset = 0; npul = 0; st = '0; sg = 1'b0;
    adjust_ready = 1'b1;
    send_frame(v);
    exp_fc = exp_fc + 16'(v.exp_inc);
    for (int c = 1; c <= 30; c++) begin
      if ((set_valid || adjust_valid) && first == 0) first = c;
      if (set_valid) begin nset++; st = set_time; end
      if (adjust_valid) begin
        if (npul == 0) sg = adjust_sign;
        npul++;
      end
      step();
    end
    check({tag, ".latency"}, 64'(first), (v.exp_set || v.exp_pulses > 0) ? 64'd2 : 64'd0);
    check({tag, ".set_pulses"}, 64'(nset), 64'(v.exp_set));
    if (v.exp_set) check({tag, ".set_time"}, st, v.exp_time);
    check({tag, ".adj_pulses"}, 64'(npul), 64'(v.exp_pulses));
    if (v.exp_pulses > 0) check({tag, ".adj_sign"}, 64'(sg), 64'(v.exp_sign));
    check({tag, ".last_error"}, 64'(last_error), 64'(v.exp_lerr));
    check({tag, ".frame_count"}, 64'(frame_count), 64'(exp_fc));
  endtask

  initial begin
    vec_t h;
    int   acc, drop, sbad;
    logic pv, pr, rdy;

    //         node   flags  master                  offset         t_start      t_end        err  set  set_time    pul sg  lerr           inc
    vecs[0]  = '{8'd1, 8'h02, 64'h1000,               32'h20,        64'h500,     64'h50A,     1'b0, 1'b1, 64'h102A, 0,  1'b0, 24'h0,        1};
    vecs[1]  = '{8'd1, 8'h01, 64'd100,                32'hAB000005,  64'd100,     64'd130,     1'b0, 1'b0, 64'h0,    5,  1'b0, 24'd5,        1};
    vecs[2]  = '{8'd0, 8'h02, 64'h1000,               32'h20,        64'h500,     64'h510,     1'b1, 1'b0, 64'h0,    0,  1'b0, 24'd5,        0};
    vecs[3]  = '{8'd5, 8'h02, 64'h200,                32'h77,        64'h300,     64'h345,     1'b0, 1'b1, 64'h245,  0,  1'b0, 24'd5,        1};
    vecs[4]  = '{8'd0, 8'h03, 64'h10,                 32'h3,         64'h10,      64'h18,      1'b0, 1'b1, 64'h1B,   0,  1'b0, 24'd5,        1};
    vecs[5]  = '{8'd0, 8'h00, 64'h10,                 32'h3,         64'h10,      64'h18,      1'b0, 1'b0, 64'h0,    0,  1'b0, 24'd5,        1};
    vecs[6]  = '{8'd0, 8'h01, 64'd50,                 32'h0,         64'd50,      64'd60,      1'b0, 1'b0, 64'h0,    0,  1'b0, 24'd0,        1};
    vecs[7]  = '{8'd1, 8'h01, 64'd1000,               32'h0,         64'd1003,    64'd1010,    1'b0, 1'b0, 64'h0,    3,  1'b1, 24'hFFFFFD,   1};
    vecs[8]  = '{8'd0, 8'h01, 64'd16,                 32'h0,         64'd0,       64'd9,       1'b0, 1'b0, 64'h0,    16, 1'b0, 24'd16,       1};
    vecs[9]  = '{8'd1, 8'h01, 64'h0,                  32'h0,         64'h800000,  64'h800005,  1'b0, 1'b0, 64'h0,    16, 1'b1, 24'h800000,   1};
    vecs[10] = '{8'd0, 8'h01, 64'h1000002,            32'h0,         64'h0,       64'h7,       1'b0, 1'b0, 64'h0,    2,  1'b0, 24'd2,        1};
    vecs[11] = '{8'd1, 8'h02, 64'hFFFF_FFFF_FFFF_FFF0, 32'h20,       64'h5,       64'h7,       1'b0, 1'b1, 64'h12,   0,  1'b0, 24'd2,        1};

    reset = 1'b0; node_id = '0; current_time = '0;
    cmd_rx_start = 0; cmd_rx_end = 0; cmd_rx_error = 0;
    cmd_payload_pos = '0; cmd_payload_data = '0; cmd_payload_valid = 0; adjust_ready = 0;
    repeat (3) step();
    reset = 1'b1;
    step();

    check("rst.set_valid",    64'(set_valid),    64'd0);
    check("rst.adjust_valid", 64'(adjust_valid), 64'd0);
    check("rst.set_time",     set_time,          64'd0);
    check("rst.last_error",   64'(last_error),   64'd0);
    check("rst.frame_count",  64'(frame_count),  64'd0);
    check("rst.adjust_sign",  64'(adjust_sign),  64'd0);

    // A stray end pulse with no frame in progress must be ignored.
    cmd_rx_end = 1'b1;
    step();
    cmd_rx_end = 1'b0;
    pv = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (set_valid || adjust_valid) pv = 1'b1;
      step();
    end
    check("stray_end.outputs",     64'(pv),          64'd0);
    check("stray_end.frame_count", 64'(frame_count), 64'(exp_fc));

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // err = 60 - 100 = -40, clipped to 16 pulses, ready alternating 1/0.
    h = '{8'd0, 8'h01, 64'd60, 32'h0, 64'd100, 64'd101, 1'b0, 1'b0, 64'h0, 0, 1'b0, 24'h0, 1};
    adjust_ready = 1'b0;
    send_frame(h);
    exp_fc++;
    acc = 0; drop = 0; sbad = 0; pv = 1'b0; pr = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (pv && !pr && !adjust_valid) drop++;
      if (adjust_valid && adjust_sign !== 1'b1) sbad++;
      rdy = (c % 2 == 1);
      adjust_ready = rdy;
      if (adjust_valid && rdy) acc++;
      pv = adjust_valid;
      pr = rdy;
      step();
    end
    adjust_ready = 1'b0;
    check("bp.accepted",    64'(acc),          64'd16);
    check("bp.drop_no_rdy", 64'(drop),         64'd0);
    check("bp.sign",        64'(sbad),         64'd0);
    check("bp.last_error",  64'(last_error),   64'hFFFFD8);
    check("bp.idle_after",  64'(adjust_valid), 64'd0);
    check("bp.frame_count", 64'(frame_count),  64'(exp_fc));

    // err = -10 with ready held low, then a new frame start aborts the pulses.
    h = '{8'd0, 8'h01, 64'd90, 32'h0, 64'd100, 64'd101, 1'b0, 1'b0, 64'h0, 0, 1'b0, 24'h0, 1};
    send_frame(h);
    exp_fc++;
    step();
    check("abort.valid_up",   64'(adjust_valid), 64'd1);
    step(); step();
    check("abort.valid_hold", 64'(adjust_valid), 64'd1);
    check("abort.last_error", 64'(last_error),   64'hFFFFF6);
    cmd_rx_start = 1'b1;
    current_time = 64'h900;
    step();
    cmd_rx_start = 1'b0;
    check("abort.valid_drop", 64'(adjust_valid), 64'd0);

    // Now mid-RECV: feed a couple of bytes, then assert reset between clock edges.
    cmd_payload_valid = 1'b1; cmd_payload_pos = 16'd1; cmd_payload_data = 8'h33;
    step();
    cmd_payload_pos = 16'd2;
    step();
    cmd_payload_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("areset.set_valid",    64'(set_valid),    64'd0);
    check("areset.adjust_valid", 64'(adjust_valid), 64'd0);
    check("areset.set_time",     set_time,          64'd0);
    check("areset.last_error",   64'(last_error),   64'd0);
    check("areset.frame_count",  64'(frame_count),  64'd0);
    check("areset.adjust_sign",  64'(adjust_sign),  64'd0);
    exp_fc = 16'd0;
    step(); step();
    reset = 1'b1;
    step();
    run_vec(vecs[0], "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
